// File: rtl/idu_pipe.sv
// Registered instruction-decode stage: decodes {pc, inst} combinationally,
// holds the decoded bundle in an output register, and optionally adds a
// skid entry so that in_ready comes straight from a flop.
module idu_pipe #(
  parameter int XLEN = 64,
  parameter int EN_M = 1,
  parameter int SKID = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_inst,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_inst,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [2:0]      out_funct3,
  output logic            out_rs1_used,
  output logic            out_rs2_used,
  output logic            out_rd_w_en,
  output logic [3:0]      out_class,
  output logic [3:0]      out_alu_op,
  output logic            out_word
);

  typedef enum logic [3:0] {
    CLS_ALU = 4'd0, CLS_LOAD = 4'd1, CLS_STORE = 4'd2, CLS_BRANCH = 4'd3,
    CLS_JAL = 4'd4, CLS_JALR = 4'd5, CLS_CSR = 4'd6, CLS_ECALL = 4'd7,
    CLS_EBREAK = 4'd8, CLS_MRET = 4'd9, CLS_MULDIV = 4'd10, CLS_FENCE = 4'd11,
    CLS_ILLEGAL = 4'd15
  } cls_e;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLT = 4'd2, ALU_SLTU = 4'd3,
    ALU_AND = 4'd4, ALU_OR = 4'd5, ALU_XOR = 4'd6, ALU_SLL = 4'd7,
    ALU_SRL = 4'd8, ALU_SRA = 4'd9
  } alu_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic            rs1_used;
    logic            rs2_used;
    logic            rd_w_en;
    cls_e            cls;
    alu_e            alu_op;
    logic            word;
  } bundle_t;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  // funct3 to ALU operation; alt selects SUB/SRA where the encoding allows it.
  function automatic alu_e alu_sel(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = in_inst[6:0];
  assign f3     = in_inst[14:12];
  assign funct7 = in_inst[31:25];
  assign imm_i  = XLEN'($signed(in_inst[31:20]));
  assign imm_s  = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
  assign imm_b  = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0}));
  assign imm_u  = XLEN'($signed({in_inst[31:12], 12'b0}));
  assign imm_j  = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0}));

  bundle_t dec;
  logic    illegal, use_rs1, use_rs2, wr_rd;

  // Combinational decode of the incoming instruction word.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    dec        = '0;
    illegal    = 1'b0;
    use_rs1    = 1'b0;
    use_rs2    = 1'b0;
    wr_rd      = 1'b0;
    dec.pc     = in_pc;
    dec.inst   = in_inst;
    dec.rs1    = in_inst[19:15];
    dec.rs2    = in_inst[24:20];
    dec.rd     = in_inst[11:7];
    dec.funct3 = f3;
    dec.cls    = CLS_ALU;
    dec.alu_op = ALU_ADD;
    case (opcode)
      OPC_LUI, OPC_AUIPC: begin
        wr_rd   = 1'b1;
        dec.imm = imm_u;
      end
      OPC_JAL: begin
        dec.cls = CLS_JAL;
        wr_rd   = 1'b1;
        dec.imm = imm_j;
      end
      OPC_JALR: begin
        dec.cls = CLS_JALR;
        use_rs1 = 1'b1;
        wr_rd   = 1'b1;
        dec.imm = imm_i;
      end
      OPC_BRANCH: begin
        dec.cls = CLS_BRANCH;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        dec.imm = imm_b;
        illegal = (f3 == 3'b010) || (f3 == 3'b011);
      end
      OPC_LOAD: begin
        dec.cls = CLS_LOAD;
        use_rs1 = 1'b1;
        wr_rd   = 1'b1;
        dec.imm = imm_i;
        illegal = (f3 == 3'b111) || (XLEN == 32 && (f3 == 3'b011 || f3 == 3'b110));
      end
      OPC_STORE: begin
        dec.cls = CLS_STORE;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        dec.imm = imm_s;
        illegal = f3[2] || (XLEN == 32 && f3 == 3'b011);
      end
      OPC_OP_IMM, OPC_OP_IMM_32: begin
        use_rs1    = 1'b1;
        wr_rd      = 1'b1;
        dec.imm    = imm_i;
        dec.word   = (opcode == OPC_OP_IMM_32);
        dec.alu_op = alu_sel(f3, in_inst[30] && f3 == 3'b101);
        if (XLEN == 32)
          illegal = dec.word || ((f3 == 3'b001 || f3 == 3'b101) && in_inst[25]);
      end
      OPC_OP, OPC_OP_32: begin
        use_rs1  = 1'b1;
        use_rs2  = 1'b1;
        wr_rd    = 1'b1;
        dec.word = (opcode == OPC_OP_32);
        if (funct7 == 7'b0000001 && EN_M != 0)
          dec.cls = CLS_MULDIV;
        else if (funct7 == 7'b0000000)
          dec.alu_op = alu_sel(f3, 1'b0);
        else if (funct7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))
          dec.alu_op = alu_sel(f3, 1'b1);
        else
          illegal = 1'b1;
        if (XLEN == 32 && dec.word)
          illegal = 1'b1;
      end
      OPC_MISC_MEM: begin
        dec.cls = CLS_FENCE;
        dec.imm = imm_i;
      end
      OPC_SYSTEM: begin
        dec.imm = imm_i;
        if (f3 == 3'b000) begin
          case (in_inst)
            32'h0000_0073: dec.cls = CLS_ECALL;
            32'h0010_0073: dec.cls = CLS_EBREAK;
            32'h3020_0073: dec.cls = CLS_MRET;
            default:       illegal = 1'b1;
          endcase
        end else if (f3 == 3'b100) begin
          illegal = 1'b1;
        end else begin
          dec.cls = CLS_CSR;
          use_rs1 = ~f3[2];
          wr_rd   = 1'b1;
        end
      end
      default: illegal = 1'b1;
    endcase

    if (illegal) begin
      dec.cls    = CLS_ILLEGAL;
      dec.alu_op = ALU_ADD;
      dec.imm    = '0;
      dec.word   = 1'b0;
      use_rs1    = 1'b0;
      use_rs2    = 1'b0;
      wr_rd      = 1'b0;
    end else if (dec.cls != CLS_ALU) begin
      dec.alu_op = ALU_ADD;
    end
    dec.rs1_used = use_rs1 && (dec.rs1 != 5'd0);
    dec.rs2_used = use_rs2 && (dec.rs2 != 5'd0);
    dec.rd_w_en  = wr_rd && (dec.rd != 5'd0);
  end

  bundle_t main_q, main_d, skid_q, skid_d;
  logic    main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
  logic    accept;

  assign in_ready = (SKID != 0) ? ~skid_valid_q : (~main_valid_q | out_ready);
  assign accept   = in_valid & in_ready & ~flush;

  // Next-state for the main/skid entries; skid only fills while main is stalled.
  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (main_valid_q && !out_ready) begin
      if (accept) begin
        skid_d       = dec;
        skid_valid_d = 1'b1;
      end
    end else if (skid_valid_q) begin
      main_d       = skid_q;
      main_valid_d = 1'b1;
      skid_valid_d = 1'b0;
    end else begin
      main_valid_d = accept;
      if (accept) main_d = dec;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    // NOTE: data registers are reset too because the bundle outputs must read 0 after reset.
    if (rst) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign out_valid    = main_valid_q;
  assign out_pc       = main_q.pc;
  assign out_inst     = main_q.inst;
  assign out_imm      = main_q.imm;
  assign out_rs1      = main_q.rs1;
  assign out_rs2      = main_q.rs2;
  assign out_rd       = main_q.rd;
  assign out_funct3   = main_q.funct3;
  assign out_rs1_used = main_q.rs1_used;
  assign out_rs2_used = main_q.rs2_used;
  assign out_rd_w_en  = main_q.rd_w_en;
  assign out_class    = main_q.cls;
  assign out_alu_op   = main_q.alu_op;
  assign out_word     = main_q.word;

endmodule

// File: tb/tb_idu_pipe.sv
// Bench for idu_pipe: a 64-bit/M/skid instance driven from a vector table
// through a scoreboard, plus a 32-bit/no-M/no-skid instance for config checks.
module tb_idu_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [63:0] in_pc, out_pc, out_imm;
  logic [31:0] in_inst, out_inst;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [2:0]  out_funct3;
  logic        out_rs1_used, out_rs2_used, out_rd_w_en, out_word;
  logic [3:0]  out_class, out_alu_op;

  logic        in_valid32, in_ready32, out_valid32, out_ready32;
  logic [31:0] in_pc32, out_pc32, out_imm32, in_inst32, out_inst32;
  logic [4:0]  out_rs1_32, out_rs2_32, out_rd_32;
  logic [2:0]  out_funct3_32;
  logic        out_rs1_used32, out_rs2_used32, out_rd_w_en32, out_word32;
  logic [3:0]  out_class32, out_alu_op32;

  idu_pipe #(.XLEN(64), .EN_M(1), .SKID(1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .out_imm(out_imm), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_funct3(out_funct3), .out_rs1_used(out_rs1_used), .out_rs2_used(out_rs2_used),
    .out_rd_w_en(out_rd_w_en), .out_class(out_class), .out_alu_op(out_alu_op),
    .out_word(out_word)
  );

  idu_pipe #(.XLEN(32), .EN_M(0), .SKID(0)) dut32 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid32), .in_ready(in_ready32), .in_pc(in_pc32), .in_inst(in_inst32),
    .out_valid(out_valid32), .out_ready(out_ready32), .out_pc(out_pc32), .out_inst(out_inst32),
    .out_imm(out_imm32), .out_rs1(out_rs1_32), .out_rs2(out_rs2_32), .out_rd(out_rd_32),
    .out_funct3(out_funct3_32), .out_rs1_used(out_rs1_used32), .out_rs2_used(out_rs2_used32),
    .out_rd_w_en(out_rd_w_en32), .out_class(out_class32), .out_alu_op(out_alu_op32),
    .out_word(out_word32)
  );

  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
    logic [3:0]  cls;
    logic [3:0]  alu;
    logic [63:0] imm;
    logic        rs1u, rs2u, rdw, word;
  } vec_t;

  typedef struct {
    logic [31:0] inst;
    logic [3:0]  cls;
    logic [31:0] imm;
  } vec32_t;

  int     errors = 0;
  int     n_checks = 0;
  int     n_out = 0;
  vec_t   vecs[$];
  vec32_t vecs32[$];
  vec_t   sb[$];
  vec_t   cur;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] inst, input logic [3:0] cls, input logic [3:0] alu,
                              input logic [63:0] imm, input logic rs1u, input logic rs2u,
                              input logic rdw, input logic word);
    vec_t v;
    v.inst = inst; v.pc = '0; v.cls = cls; v.alu = alu; v.imm = imm;
    v.rs1u = rs1u; v.rs2u = rs2u; v.rdw = rdw; v.word = word;
    return v;
  endfunction

  function automatic vec32_t mk32(input logic [31:0] inst, input logic [3:0] cls, input logic [31:0] imm);
    vec32_t v;
    v.inst = inst; v.cls = cls; v.imm = imm;
    return v;
  endfunction

  task automatic compare_out(input vec_t e);
    logic [31:0] ei;
    ei = e.inst;
    check($sformatf("inst[%08h]", ei), out_inst, ei);
    check($sformatf("pc[%08h]", ei), out_pc, e.pc);
    check($sformatf("class[%08h]", ei), out_class, e.cls);
    check($sformatf("alu_op[%08h]", ei), out_alu_op, e.alu);
    check($sformatf("imm[%08h]", ei), out_imm, e.imm);
    check($sformatf("rs1_used[%08h]", ei), out_rs1_used, e.rs1u);
    check($sformatf("rs2_used[%08h]", ei), out_rs2_used, e.rs2u);
    check($sformatf("rd_w_en[%08h]", ei), out_rd_w_en, e.rdw);
    check($sformatf("word[%08h]", ei), out_word, e.word);
    check($sformatf("fields[%08h]", ei), {out_funct3, out_rs2, out_rs1, out_rd},
          {ei[14:12], ei[24:20], ei[19:15], ei[11:7]});
  endtask

  // One clock: inputs are sampled at the negedge, transfers scored, then step past the posedge.
  task automatic tick(output bit accepted);
    @(negedge clk);
    accepted = in_valid && in_ready && !flush && !rst;
    if (out_valid && out_ready && !rst && !flush) begin
      n_checks++;
      n_out++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL spurious_out: got inst %h with empty scoreboard, expected no output", out_inst);
      end else begin
        compare_out(sb.pop_front());
      end
    end
    if (rst || flush) sb.delete();
    else if (accepted) sb.push_back(cur);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input vec_t v, input bit rnd);
    bit acc;
    acc = 1'b0;
    cur = v; in_inst = v.inst; in_pc = v.pc; in_valid = 1'b1;
    for (int t = 0; t < 50 && !acc; t++) begin
      if (rnd) out_ready = ($urandom_range(0, 3) != 0);
      tick(acc);
    end
    if (!acc) begin
      n_checks++; errors++;
      $display("FAIL send_timeout: inst %h never accepted, expected acceptance", v.inst);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit acc;
    out_ready = 1'b1;
    in_valid = 1'b0;
    for (int t = 0; t < 20 && sb.size() != 0; t++) tick(acc);
    check("drain_empty", sb.size(), 0);
  endtask

  initial begin
    bit acc;
    int out_before;
    logic [31:0] held;

    vecs.push_back(mk(32'hFFF00093, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 1, 0));
    vecs.push_back(mk(32'hFE208EE3, 3, 0, 64'hFFFF_FFFF_FFFF_FFFC, 1, 1, 0, 0));
    vecs.push_back(mk(32'h022081B3, 10, 0, 64'h0, 1, 1, 1, 0));
    vecs.push_back(mk(32'h402081B3, 0, 1, 64'h0, 1, 1, 1, 0));
    vecs.push_back(mk(32'h002080BB, 0, 0, 64'h0, 1, 1, 1, 1));
    vecs.push_back(mk(32'h800002B7, 0, 0, 64'hFFFF_FFFF_8000_0000, 0, 0, 1, 0));
    vecs.push_back(mk(32'h0020B423, 2, 0, 64'h8, 1, 1, 0, 0));
    vecs.push_back(mk(32'hFF80B303, 1, 0, 64'hFFFF_FFFF_FFFF_FFF8, 1, 0, 1, 0));
    vecs.push_back(mk(32'h010000EF, 4, 0, 64'h10, 0, 0, 1, 0));
    vecs.push_back(mk(32'h00008067, 5, 0, 64'h0, 1, 0, 0, 0));
    vecs.push_back(mk(32'h300092F3, 6, 0, 64'h300, 1, 0, 1, 0));
    vecs.push_back(mk(32'h3002E073, 6, 0, 64'h300, 0, 0, 0, 0));
    vecs.push_back(mk(32'h00100073, 8, 0, 64'h1, 0, 0, 0, 0));
    vecs.push_back(mk(32'h30200073, 9, 0, 64'h302, 0, 0, 0, 0));
    vecs.push_back(mk(32'h00000073, 7, 0, 64'h0, 0, 0, 0, 0));
    vecs.push_back(mk(32'h00200073, 15, 0, 64'h0, 0, 0, 0, 0));
    vecs.push_back(mk(32'h0FF0000F, 11, 0, 64'hFF, 0, 0, 0, 0));
    vecs.push_back(mk(32'h4030D093, 0, 9, 64'h403, 1, 0, 1, 0));
    vecs.push_back(mk(32'h202081B3, 15, 0, 64'h0, 0, 0, 0, 0));
    vecs.push_back(mk(32'h00000000, 15, 0, 64'h0, 0, 0, 0, 0));
    vecs.push_back(mk(32'h0020A063, 15, 0, 64'h0, 0, 0, 0, 0));
    vecs.push_back(mk(32'h00113093, 0, 3, 64'h1, 1, 0, 1, 0));
    vecs.push_back(mk(32'h0000F083, 15, 0, 64'h0, 0, 0, 0, 0));
    foreach (vecs[i]) vecs[i].pc = 64'h8000_0000 + 64'(i) * 4;

    vecs32.push_back(mk32(32'h002080BB, 15, 32'h0));
    vecs32.push_back(mk32(32'h022081B3, 15, 32'h0));
    vecs32.push_back(mk32(32'hFFF00093, 0, 32'hFFFF_FFFF));
    vecs32.push_back(mk32(32'h800002B7, 0, 32'h8000_0000));
    vecs32.push_back(mk32(32'hFF80B303, 15, 32'h0));
    vecs32.push_back(mk32(32'h02009093, 15, 32'h0));
    vecs32.push_back(mk32(32'h0020B423, 15, 32'h0));

    rst = 1'b1; flush = 1'b0;
    in_valid = 1'b0; in_pc = '0; in_inst = '0; out_ready = 1'b1;
    in_valid32 = 1'b0; in_pc32 = '0; in_inst32 = '0; out_ready32 = 1'b1;
    cur = vecs[0];
    tick(acc);
    tick(acc);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_pc", out_pc, 0);
    check("rst_out_imm", out_imm, 0);
    check("rst_out_inst_class", {out_inst, out_class, out_alu_op}, 0);
    check("rst_out_valid32", out_valid32, 0);
    rst = 1'b0;
    tick(acc);
    check("post_rst_in_ready", in_ready, 1);

    // Full-throughput pass, then a pass with random downstream backpressure.
    foreach (vecs[i]) send(vecs[i], 1'b0);
    drain();
    foreach (vecs[i]) send(vecs[i], 1'b1);
    drain();

    // Skid fill: A in main, B in skid, C waits while in_ready is low.
    out_ready = 1'b0;
    out_before = n_out;
    send(vecs[0], 1'b0);
    send(vecs[1], 1'b0);
    cur = vecs[2]; in_inst = vecs[2].inst; in_pc = vecs[2].pc; in_valid = 1'b1;
    check("skid_full_in_ready", in_ready, 0);
    check("skid_full_out_valid", out_valid, 1);
    held = out_inst;
    tick(acc);
    check("skid_c_not_accepted", acc, 0);
    check("hold_inst_stable", out_inst, held);
    check("hold_main_is_a", out_inst, vecs[0].inst);
    out_ready = 1'b1;
    acc = 1'b0;
    for (int t = 0; t < 10 && !acc; t++) tick(acc);
    check("skid_c_accepted", acc, 1);
    in_valid = 1'b0;
    drain();
    check("skid_out_count", n_out - out_before, 3);

    // Flush with main + skid held and a third instruction presented.
    out_ready = 1'b0;
    out_before = n_out;
    send(vecs[3], 1'b0);
    send(vecs[5], 1'b0);
    cur = vecs[6]; in_inst = vecs[6].inst; in_pc = vecs[6].pc; in_valid = 1'b1;
    flush = 1'b1;
    tick(acc);
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_out_valid", out_valid, 0);
    check("flush_in_ready", in_ready, 1);
    out_ready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      tick(acc);
      check($sformatf("flush_idle_valid_%0d", t), out_valid, 0);
    end
    check("flush_out_count", n_out - out_before, 0);

    // 32-bit, no-M, no-skid configuration.
    foreach (vecs32[i]) begin
      in_inst32 = vecs32[i].inst; in_pc32 = 32'h100 + 32'(i) * 4; in_valid32 = 1'b1;
      tick(acc);
      in_valid32 = 1'b0;
      check($sformatf("cfg32_valid[%08h]", vecs32[i].inst), out_valid32, 1);
      check($sformatf("cfg32_class[%08h]", vecs32[i].inst), out_class32, vecs32[i].cls);
      check($sformatf("cfg32_imm[%08h]", vecs32[i].inst), out_imm32, vecs32[i].imm);
      tick(acc);
    end
    out_ready32 = 1'b0;
    in_inst32 = 32'hFFF00093; in_valid32 = 1'b1;
    #1;
    check("cfg32_in_ready_empty", in_ready32, 1);
    tick(acc);
    in_valid32 = 1'b0;
    check("cfg32_stall_valid", out_valid32, 1);
    check("cfg32_in_ready_stalled", in_ready32, 0);
    out_ready32 = 1'b1;
    #1;
    check("cfg32_in_ready_draining", in_ready32, 1);
    tick(acc);
    check("cfg32_drained", out_valid32, 0);

    $display("Result: errors=%0d of %0d checks", errors, n_checks);
    $finish;
  end

endmodule
